// File: rtl/ysyx_22051013_if_fetch_pkg.sv
// Shared definitions for the IF fetch sequencer: fetch/instruction widths,
// the post-reset fetch address and the fetch FSM state encoding.
package ysyx_22051013_if_fetch_pkg;

  localparam int          IF_PC_W     = 64;
  localparam int          IF_INST_W   = 32;
  localparam logic [63:0] IF_RESET_PC = 64'h8000_0000;

  // IDLE: one dead cycle out of reset
  // REQ : request on the imem port
  // WAIT: one request accepted, response outstanding
  // HOLD: instruction registered and offered to ID
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/ysyx_22051013_if_perf.sv
// Fetch performance counters: handshakes, dropped/killed fetches and ID
// backpressure cycles. Free-running 64-bit counters, cleared by rst.
module ysyx_22051013_if_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch,
  input  logic        i_drop,
  input  logic        i_stall,
  output logic [63:0] o_fetch,
  output logic [63:0] o_drop,
  output logic [63:0] o_stall
);

  logic [63:0] r_fetch;
  logic [63:0] r_drop;
  logic [63:0] r_stall;

  // Count each event strobe; natural wrap at 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch <= 64'd0;
      r_drop  <= 64'd0;
      r_stall <= 64'd0;
    end else begin
      if (i_fetch) r_fetch <= r_fetch + 64'd1;
      if (i_drop)  r_drop  <= r_drop  + 64'd1;
      if (i_stall) r_stall <= r_stall + 64'd1;
    end
  end

  assign o_fetch = r_fetch;
  assign o_drop  = r_drop;
  assign o_stall = r_stall;

endmodule

// File: rtl/ysyx_22051013_if_fetch.sv
// PC register and instruction-fetch sequencer feeding the IF->ID boundary.
// One imem request outstanding at a time; a flush retargets the PC and
// discards whatever fetch is in flight or held. An accepted request always
// returns exactly one response, so a flush during WAIT marks that response
// for discard instead of abandoning it.
// Optional: define YSYX_22051013_IF_PERF_EN to add perf_fetch_o,
// perf_drop_o and perf_stall_o counters.
import ysyx_22051013_if_fetch_pkg::*;

module ysyx_22051013_if_fetch #(
  parameter int               PC_W     = IF_PC_W,
  parameter int               INST_W   = IF_INST_W,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   pc_next_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              imem_rsp_ready_o,
  output logic              if_valid_o,
  output logic [PC_W-1:0]   if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              id_ready_i
`ifdef YSYX_22051013_IF_PERF_EN
  ,
  output logic [63:0]       perf_fetch_o,
  output logic [63:0]       perf_drop_o,
  output logic [63:0]       perf_stall_o
`endif
);

  if_state_e         r_state;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_discard;

  // Fetch FSM: PC, held instruction and discard flag all move together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (flush_i) r_pc <= pc_next_i;
        end
        S_REQ: begin
          // Address only moves on flush; once accepted a flush turns the
          // in-flight response into one that must be drained and dropped.
          if (flush_i) r_pc <= pc_next_i;
          if (imem_req_ready_i) begin
            r_state <= S_WAIT;
            if (flush_i) r_discard <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            if (r_discard || flush_i) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
              if (flush_i) r_pc <= pc_next_i;
            end else begin
              r_inst  <= imem_rsp_data_i;
              r_state <= S_HOLD;
            end
          end else if (flush_i) begin
            r_discard <= 1'b1;
            r_pc      <= pc_next_i;
          end
        end
        S_HOLD: begin
          // Flush kills the held instruction even if ID is ready
          if (flush_i || id_ready_i) begin
            r_pc    <= pc_next_i;
            r_state <= S_REQ;
          end
        end
      endcase
    end
  end

  assign imem_req_addr_o  = r_pc;
  assign if_pc_o          = r_pc;
  assign if_inst_o        = r_inst;
  assign imem_req_valid_o = (r_state == S_REQ);
  assign imem_rsp_ready_o = (r_state == S_WAIT);
  assign if_valid_o       = (r_state == S_HOLD) && !flush_i;

`ifdef YSYX_22051013_IF_PERF_EN
  logic w_fetch;
  logic w_drop;
  logic w_stall;

  assign w_fetch = (r_state == S_HOLD) && id_ready_i && !flush_i;
  assign w_drop  = ((r_state == S_WAIT) && imem_rsp_valid_i && (r_discard || flush_i))
                || ((r_state == S_HOLD) && flush_i);
  assign w_stall = (r_state == S_HOLD) && !id_ready_i;

  ysyx_22051013_if_perf u_perf (
    .clk     (clk),
    .rst     (rst),
    .i_fetch (w_fetch),
    .i_drop  (w_drop),
    .i_stall (w_stall),
    .o_fetch (perf_fetch_o),
    .o_drop  (perf_drop_o),
    .o_stall (perf_stall_o)
  );
`endif

endmodule
